// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - host/display-side bundle for the seven-segment scan controller
// Ports (master = host side, slave = display_scan_ctrl):
//   digit_en, brightness, digits_in, upd_req  host -> scanner
//   upd_ack, anode_en, sshow, frame_start      scanner -> host/display
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 2
);
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              brightness;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    upd_req;
    logic                    upd_ack;
    logic [NUM_DIGITS-1:0]   anode_en;
    logic [3:0]              sshow;
    logic                    frame_start;

    modport master (
        output digit_en, brightness, digits_in, upd_req,
        input  upd_ack, anode_en, sshow, frame_start
    );

    modport slave (
        input  digit_en, brightness, digits_in, upd_req,
        output upd_ack, anode_en, sshow, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed seven-segment scan scheduler with PWM and shadowed digits
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    display_scan_ctrl_if.slave: digit_en, brightness, digits_in, upd_req in;
//          upd_ack, anode_en (one-hot/zero), sshow, frame_start out (all registered)
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 262144,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    display_scan_ctrl_if.slave   bus
);
    localparam int IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX);
    localparam logic [CNTW-1:0]       DWELL_LAST = CNTW'(DWELL_CYCLES - 1);
    localparam logic [CNTW-1:0]       BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE        = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                  state;
    logic [IDXW-1:0]         idx;
    logic [CNTW-1:0]         cnt;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic                    first_found;
    logic [IDXW-1:0]         first_idx;
    logic                    next_found;
    logic [IDXW-1:0]         next_idx;
    logic [CNTW-1:0]         cnt_inc;
    logic                    go;
    logic [IDXW-1:0]         go_idx;
    logic                    boundary;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] new_shadow;
    logic [3:0]              go_val;
    logic [NUM_DIGITS-1:0]   lit;

    always_comb begin
        int j;
        j           = 0;
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!first_found && bus.digit_en[i]) begin
                first_found = 1'b1;
                first_idx   = IDXW'(i);
            end
        end
        // Round-robin search starting just above the current digit; k==NUM_DIGITS
        // lands back on idx itself so a lone enabled digit keeps being scanned.
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            j = (int'(idx) + k) % NUM_DIGITS;
            if (!next_found && bus.digit_en[j]) begin
                next_found = 1'b1;
                next_idx   = IDXW'(j);
            end
        end
    end

    always_comb begin
        cnt_inc  = cnt + CNTW'(1);
        go       = ((state == IDLE) && first_found) ||
                   ((state == BLANK) && (cnt == BLANK_LAST) && next_found);
        go_idx   = (state == IDLE) ? first_idx : next_idx;
        // Wrapping back to an equal or lower digit closes the frame.
        boundary = (state == IDLE) || (next_idx <= idx);
        // Shadow only changes at frame boundaries, or immediately when the scanner is idle.
        load     = bus.upd_req && ((go && boundary) || ((state == IDLE) && !first_found));
        new_shadow = load ? bus.digits_in : shadow;
        go_val   = new_shadow[{go_idx, 2'b00} +: 4];
        // Outputs are registered, so PWM is decided against the count about to be shown.
        lit      = (cnt_inc[3:0] <= bus.brightness) ? (ONE << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            shadow          <= '0;
            bus.anode_en    <= '0;
            bus.sshow       <= '0;
            bus.upd_ack     <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            shadow          <= new_shadow;
            bus.upd_ack     <= load;
            bus.frame_start <= go && boundary;
            case (state)
                IDLE: begin
                    bus.anode_en <= '0;
                    bus.sshow    <= '0;
                    if (go) begin
                        state        <= SHOW;
                        idx          <= go_idx;
                        cnt          <= '0;
                        bus.anode_en <= ONE << go_idx;
                        bus.sshow    <= go_val;
                    end
                end
                SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state        <= BLANK;
                        cnt          <= '0;
                        bus.anode_en <= '0;
                    end else begin
                        cnt          <= cnt_inc;
                        bus.anode_en <= lit;
                    end
                end
                BLANK: begin
                    bus.anode_en <= '0;
                    if (cnt == BLANK_LAST) begin
                        cnt <= '0;
                        if (go) begin
                            state        <= SHOW;
                            idx          <= go_idx;
                            bus.anode_en <= ONE << go_idx;
                            bus.sshow    <= go_val;
                        end else begin
                            state     <= IDLE;
                            bus.sshow <= '0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;
    localparam int ND = 2;
    localparam int DW = 16;
    localparam int BL = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   passed   = 0;
    int   inv_viol = 0;
    logic [ND-1:0] last_nz = '0;
    int   zrun = 0;

    display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // One-hot and inter-digit blanking monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if ($countones(bus.anode_en) > 1) inv_viol++;
            if (bus.anode_en != '0) begin
                if (last_nz != '0 && bus.anode_en != last_nz && zrun < BL) inv_viol++;
                last_nz = bus.anode_en;
                zrun = 0;
            end else begin
                zrun++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.digit_en   = '0;
        bus.brightness = 4'd15;
        bus.digits_in  = '0;
        bus.upd_req    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.anode_en !== 2'b00) $display("FAIL reset_anode got %b exp 00", bus.anode_en); else passed++;
        checks++; if (bus.sshow !== 4'h0) $display("FAIL reset_sshow got %h exp 0", bus.sshow); else passed++;
        checks++; if (bus.frame_start !== 1'b0) $display("FAIL reset_frame_start got %b exp 0", bus.frame_start); else passed++;
        checks++; if (bus.upd_ack !== 1'b0) $display("FAIL reset_upd_ack got %b exp 0", bus.upd_ack); else passed++;
    endtask

    task automatic test_idle_load();
        reset = 1'b0;
        bus.upd_req   = 1'b1;
        bus.digits_in = 8'h37;
        tick();
        checks++; if (bus.upd_ack !== 1'b1) $display("FAIL idle_ack got %b exp 1", bus.upd_ack); else passed++;
        checks++; if (bus.anode_en !== 2'b00 || bus.sshow !== 4'h0 || bus.frame_start !== 1'b0)
            $display("FAIL idle_outputs got anode=%b sshow=%h fs=%b exp 00/0/0", bus.anode_en, bus.sshow, bus.frame_start);
        else passed++;
        bus.upd_req = 1'b0;
        tick();
        checks++; if (bus.upd_ack !== 1'b0) $display("FAIL idle_ack_drop got %b exp 0", bus.upd_ack); else passed++;
    endtask

    task automatic test_scan();
        int p;
        logic [1:0] ea;
        logic [3:0] es;
        bus.digit_en   = 2'b11;
        bus.brightness = 4'd15;
        for (int c = 0; c < 72; c++) begin
            tick();
            p  = c % 36;
            ea = (p < 16) ? 2'b01 : (p < 18) ? 2'b00 : (p < 34) ? 2'b10 : 2'b00;
            es = (p < 18) ? 4'h7 : 4'h3;
            checks++;
            if (bus.anode_en !== ea || bus.sshow !== es || bus.frame_start !== (p == 0))
                $display("FAIL scan c=%0d got anode=%b sshow=%h fs=%b exp %b/%h/%b",
                         c, bus.anode_en, bus.sshow, bus.frame_start, ea, es, (p == 0));
            else passed++;
        end
    endtask

    task automatic test_pwm();
        int p, cn, b;
        logic [1:0] ea;
        bus.brightness = 4'd3;
        for (int c = 0; c < 72; c++) begin
            tick();
            p  = c % 36;
            b  = (c < 36) ? 3 : 0;
            cn = (p < 16) ? p : (p >= 18 && p < 34) ? p - 18 : -1;
            ea = (cn >= 0 && cn <= b) ? ((p < 18) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (bus.anode_en !== ea)
                $display("FAIL pwm c=%0d got anode=%b exp %b", c, bus.anode_en, ea);
            else passed++;
            if (c == 35) bus.brightness = 4'd0;
        end
    endtask

    task automatic test_single();
        int p;
        logic [1:0] ea;
        bus.brightness = 4'd15;
        bus.digit_en   = 2'b10;
        for (int c = 0; c < 36; c++) begin
            tick();
            p  = c % 18;
            ea = (p < 16) ? 2'b10 : 2'b00;
            checks++;
            if (bus.anode_en !== ea || bus.sshow !== 4'h3 || bus.frame_start !== (p == 0))
                $display("FAIL single c=%0d got anode=%b sshow=%h fs=%b exp %b/3/%b",
                         c, bus.anode_en, bus.sshow, bus.frame_start, ea, (p == 0));
            else passed++;
        end
    endtask

    task automatic test_update();
        int p, fr;
        logic [1:0] ea;
        logic [3:0] es;
        bus.digit_en = 2'b11;
        for (int c = 0; c < 72; c++) begin
            tick();
            p  = c % 36;
            fr = c / 36;
            ea = (p < 16) ? 2'b01 : (p < 18) ? 2'b00 : (p < 34) ? 2'b10 : 2'b00;
            es = (p < 18) ? ((fr != 0) ? 4'h5 : 4'h7) : ((fr != 0) ? 4'hA : 4'h3);
            checks++;
            if (bus.anode_en !== ea || bus.sshow !== es || bus.frame_start !== (p == 0) || bus.upd_ack !== (c == 36))
                $display("FAIL update c=%0d got anode=%b sshow=%h fs=%b ack=%b exp %b/%h/%b/%b",
                         c, bus.anode_en, bus.sshow, bus.frame_start, bus.upd_ack, ea, es, (p == 0), (c == 36));
            else passed++;
            if (c == 4) begin
                bus.upd_req   = 1'b1;
                bus.digits_in = 8'hA5;
            end
            if (c == 36) bus.upd_req = 1'b0;
        end
    endtask

    task automatic test_disable();
        logic [1:0] ea;
        logic [3:0] es;
        for (int c = 0; c < 24; c++) begin
            tick();
            ea = (c < 16 || c >= 22) ? 2'b01 : 2'b00;
            es = (c >= 18 && c < 22) ? 4'h0 : 4'h5;
            checks++;
            if (bus.anode_en !== ea || bus.sshow !== es || bus.frame_start !== (c == 0 || c == 22))
                $display("FAIL disable c=%0d got anode=%b sshow=%h fs=%b exp %b/%h/%b",
                         c, bus.anode_en, bus.sshow, bus.frame_start, ea, es, (c == 0 || c == 22));
            else passed++;
            if (c == 5)  bus.digit_en = 2'b00;
            if (c == 21) bus.digit_en = 2'b01;
        end
    endtask

    task automatic test_reset_mid();
        bus.upd_req   = 1'b1;
        bus.digits_in = 8'hC9;
        reset = 1'b1;
        tick();
        checks++; if (bus.anode_en !== 2'b00) $display("FAIL rstmid_anode got %b exp 00", bus.anode_en); else passed++;
        checks++; if (bus.sshow !== 4'h0) $display("FAIL rstmid_sshow got %h exp 0", bus.sshow); else passed++;
        checks++; if (bus.frame_start !== 1'b0) $display("FAIL rstmid_frame_start got %b exp 0", bus.frame_start); else passed++;
        checks++; if (bus.upd_ack !== 1'b0) $display("FAIL rstmid_upd_ack got %b exp 0", bus.upd_ack); else passed++;
        reset = 1'b0;
        bus.upd_req = 1'b0;
        tick();
        checks++;
        if (bus.anode_en !== 2'b01 || bus.sshow !== 4'h0 || bus.frame_start !== 1'b1 || bus.upd_ack !== 1'b0)
            $display("FAIL rstmid_restart got anode=%b sshow=%h fs=%b ack=%b exp 01/0/1/0",
                     bus.anode_en, bus.sshow, bus.frame_start, bus.upd_ack);
        else passed++;
        checks++; if (inv_viol !== 0) $display("FAIL invariants got %0d violations exp 0", inv_viol); else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_load();
        test_scan();
        test_pwm();
        test_single();
        test_update();
        test_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
